// File: rtl/rgb_fade_pwm.sv
// RGB PWM driver for three active-low LEDs, fading each channel one level per step toward its target.
// Define RGB_FADE_GAMMA_EN for squared (perceptual) duty instead of linear duty.
module rgb_fade_pwm #(
    parameter int P_PWM_BITS  = 8,
    parameter int P_RATE_BITS = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [3*P_PWM_BITS-1:0]   i_color,
    input  logic [P_RATE_BITS-1:0]    i_fade_rate,
    output logic                      o_busy,
    output logic                      o_led_r,
    output logic                      o_led_g,
    output logic                      o_led_b
);

    localparam int W = P_PWM_BITS;
    localparam logic [W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE,
        FADE
    } state_t;

    state_t                   state_q, state_d;
    logic [W-1:0]             cnt_q;
    logic [2:0][W-1:0]        lvl_q, lvl_d;
    logic [2:0][W-1:0]        tgt_q;
    logic [2:0][W-1:0]        duty_q, duty_d;
    logic [P_RATE_BITS-1:0]   rate_q;
    logic [P_RATE_BITS-1:0]   step_q, step_d;
    logic [2:0]               led_q;
    logic                     wrap;
    logic                     accept;

    assign wrap    = (cnt_q == CNT_MAX);
    assign o_ready = (state_q == IDLE);
    assign o_busy  = (state_q == FADE);
    assign accept  = i_valid && o_ready;

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        step_d  = step_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    step_d = '0;
                    if (i_color != lvl_q) state_d = FADE;
                end
            end
            FADE: begin
                if (wrap) begin
                    if (rate_q == '0) begin
                        lvl_d = tgt_q;
                    end else if (step_q == rate_q - 1'b1) begin
                        step_d = '0;
                        for (int c = 0; c < 3; c++) begin
                            if (lvl_q[c] < tgt_q[c])
                                lvl_d[c] = lvl_q[c] + 1'b1;
                            else if (lvl_q[c] > tgt_q[c])
                                lvl_d[c] = lvl_q[c] - 1'b1;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                    if (lvl_d == tgt_q) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef RGB_FADE_GAMMA_EN
    logic [2*W-1:0] sq;
    always_comb begin
        sq     = '0;
        duty_d = '0;
        for (int c = 0; c < 3; c++) begin
            sq        = {{W{1'b0}}, lvl_d[c]} * {{W{1'b0}}, lvl_d[c]};
            duty_d[c] = sq[2*W-1:W];
        end
    end
`else
    always_comb begin
        duty_d = lvl_d;
    end
`endif

    // duty is only reloaded on wrap so each PWM period sees a single level
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lvl_q   <= '0;
            tgt_q   <= '0;
            duty_q  <= '0;
            rate_q  <= '0;
            step_q  <= '0;
            led_q   <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_q + 1'b1;
            lvl_q   <= lvl_d;
            step_q  <= step_d;
            if (accept) begin
                tgt_q  <= i_color;
                rate_q <= i_fade_rate;
            end
            if (wrap) duty_q <= duty_d;
            for (int c = 0; c < 3; c++)
                led_q[c] <= ~(duty_q[c] > cnt_q);
        end
    end

    assign o_led_r = led_q[2];
    assign o_led_g = led_q[1];
    assign o_led_b = led_q[0];

endmodule

// File: tb/tb_rgb_fade_pwm.sv
// Bench for rgb_fade_pwm: period-level fade model checked every cycle plus directed duty counts.
module tb_rgb_fade_pwm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [23:0] color;
    logic [7:0]  rate;
    logic        ready, busy, led_r, led_g, led_b;

    int n_chk  = 0;
    int n_pass = 0;

    int   m_cnt;
    int   m_lvl[3];
    int   m_tgt[3];
    int   m_rate;
    int   m_step;
    bit   m_busy;
    int   exp_o;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    rgb_fade_pwm #(
        .P_PWM_BITS (8),
        .P_RATE_BITS(8)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (valid),
        .o_ready    (ready),
        .i_color    (color),
        .i_fade_rate(rate),
        .o_busy     (busy),
        .o_led_r    (led_r),
        .o_led_g    (led_g),
        .o_led_b    (led_b)
    );

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int duty(input int l);
`ifdef RGB_FADE_GAMMA_EN
        return (l * l) >> 8;
`else
        return l;
`endif
    endfunction

    // spec-level model: levels per period, LED lit while duty exceeds the PWM phase
    always @(posedge clk) begin
        int leds;
        if (!rst_n) begin
            m_cnt  = 0;
            m_busy = 0;
            m_rate = 0;
            m_step = 0;
            for (int c = 0; c < 3; c++) begin
                m_lvl[c] = 0;
                m_tgt[c] = 0;
            end
            leds = 7;
        end else begin
            leds = 0;
            for (int c = 0; c < 3; c++)
                if (!(duty(m_lvl[c]) > m_cnt)) leds |= (4 >> c);
            if (!m_busy && valid) begin
                m_tgt[0] = color[23:16];
                m_tgt[1] = color[15:8];
                m_tgt[2] = color[7:0];
                m_rate   = rate;
                m_step   = 0;
                m_busy   = (m_tgt != m_lvl);
            end else if (m_busy && m_cnt == 255) begin
                if (m_rate == 0) begin
                    m_lvl = m_tgt;
                end else if (m_step == m_rate - 1) begin
                    m_step = 0;
                    for (int c = 0; c < 3; c++)
                        if (m_lvl[c] < m_tgt[c]) m_lvl[c]++;
                        else if (m_lvl[c] > m_tgt[c]) m_lvl[c]--;
                end else begin
                    m_step++;
                end
                if (m_lvl == m_tgt) m_busy = 0;
            end
            m_cnt = (m_cnt + 1) % 256;
        end
        exp_o = ((m_busy ? 0 : 1) << 4) | ((m_busy ? 1 : 0) << 3) | leds;
    end

    always @(negedge clk)
        if (chk_en) check("cycle", {27'd0, ready, busy, led_r, led_g, led_b}, exp_o);

    task automatic send_cmd(input logic [23:0] col, input logic [7:0] rt);
        int n = 0;
        while (m_cnt != 100 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready", ready, 1);
        valid = 1'b1;
        color = col;
        rate  = rt;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("idle_timeout", 0, 1);
    endtask

    // counts lit (low) samples over exactly one PWM period as seen on the pins
    task automatic measure(output int lr, output int lg, output int lb);
        int n = 0;
        lr = 0;
        lg = 0;
        lb = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_cnt != 1 && n < 300);
        if (m_cnt != 1) check("period_align", m_cnt, 1);
        for (int i = 0; i < 256; i++) begin
            if (i > 0) @(negedge clk);
            lr += (led_r == 1'b0);
            lg += (led_g == 1'b0);
            lb += (led_b == 1'b0);
        end
    endtask

    int r, g, b;
    int n;
    int rate3_exp[9] = '{10, 10, 9, 9, 9, 8, 8, 8, 7};

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        color = '0;
        rate  = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        check("rst_leds", {led_r, led_g, led_b}, 7);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        repeat (1000) @(negedge clk);
        check("quiet_leds", {led_r, led_g, led_b}, 7);
        check("quiet_ready", ready, 1);

        send_cmd(24'hFF0080, 8'd0);
        n = 0;
        while (!ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("ready_after_wrap", (ready && m_cnt <= 1) ? 1 : 0, 1);
        measure(r, g, b);
        check("jump_r", r, 255);
        check("jump_g", g, 0);
        check("jump_b", b, 128);

        send_cmd(24'h000000, 8'd0);
        wait_idle();
        send_cmd(24'h0A0000, 8'd1);
        for (int p = 1; p <= 10; p++) begin
            measure(r, g, b);
            check($sformatf("ramp_r_%0d", p), r, p);
            check($sformatf("ramp_g_%0d", p), g, 0);
            check($sformatf("ramp_busy_%0d", p), busy, (p <= 8) ? 1 : 0);
            if (p == 2) begin
                valid = 1'b1;
                color = 24'h00FF00;
            end
            if (p == 4) valid = 1'b0;
        end
        check("ramp_b", b, 0);

        send_cmd(24'h070000, 8'd3);
        for (int p = 1; p <= 9; p++) begin
            measure(r, g, b);
            check($sformatf("rate3_r_%0d", p), r, rate3_exp[p-1]);
            check($sformatf("rate3_busy_%0d", p), busy, (p <= 7) ? 1 : 0);
        end

        send_cmd(24'h000000, 8'd0);
        wait_idle();
        send_cmd(24'h0A0000, 8'd1);
        for (int p = 1; p <= 5; p++) begin
            measure(r, g, b);
            check($sformatf("pre_rst_r_%0d", p), r, p);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_leds", {led_r, led_g, led_b}, 7);
        check("midrst_ready", ready, 1);
        check("midrst_busy", busy, 0);
        measure(r, g, b);
        check("post_rst_r", r, 0);

        send_cmd(24'h80FF00, 8'd0);
        wait_idle();
        measure(r, g, b);
`ifdef RGB_FADE_GAMMA_EN
        check("gamma_r", r, 64);
        check("gamma_g", g, 254);
`else
        check("linear_r", r, 128);
        check("linear_g", g, 255);
`endif
        check("final_b", b, 0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
